// File: rtl/hex_scan_display_pkg.sv
// Shared types and constants for the hex scan display: segment table, idle
// patterns and digit-index type.
package hex_scan_display_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [1:0] digit_idx_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Active-low {g,f,e,d,c,b,a} patterns for hex 0..F
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [3:0] an_sel(digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/hex_scan_display_if.sv
// Load/display bus between the number datapath and the 7-segment scanner.
interface hex_scan_display_if;
  logic [15:0] data;
  logic        load;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_done;

  modport master (output data, load, dp_in, digit_en,
                  input  an, seg, frame_done);
  modport slave  (input  data, load, dp_in, digit_en,
                  output an, seg, frame_done);
endinterface

// File: rtl/hex_scan_display_hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex_to_seg
  import hex_scan_display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = SEG_TABLE[hex];
endmodule

// File: rtl/hex_scan_display.sv
// 4-digit multiplexed hex display with staged loads swapped in on frame edges.
// Optional LEADING_ZERO_BLANK_EN blanks digits above the top nonzero digit.
module hex_scan_display
  import hex_scan_display_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int CNT_W        = 17
) (
  input  logic clk,
  input  logic rst,
  hex_scan_display_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  digit_idx_t       idx;
  logic             pending;
  logic [15:0]      stg_data, shd_data;
  logic [3:0]       stg_dp, stg_en, shd_dp, shd_en;
  logic [3:0]       an_q;
  logic [7:0]       seg_q;
  logic             fd_q;

  logic             wrap, boundary;
  logic [NUM_DIGITS-1:0][6:0] pat;
  logic [3:0]       show;
  logic             lit;
  logic [3:0]       an_d;
  logic [7:0]       seg_d;

  assign wrap     = (cnt == CNT_LAST);
  assign boundary = wrap && (idx == 2'd3);

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    hex_to_seg u_dec (.hex(shd_data[4*g +: 4]), .seg(pat[g]));
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit survives if it or any digit above it is nonzero; digit0 always does.
  logic [3:0] keep;
  assign keep = {|shd_data[15:12], |shd_data[15:8], |shd_data[15:4], 1'b1};
  assign show = shd_en & keep;
`else
  assign show = shd_en;
`endif

  always_comb begin
    lit   = show[idx];
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (lit) begin
      an_d  = an_sel(idx);
      seg_d = {~shd_dp[idx], pat[idx]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      idx      <= '0;
      pending  <= 1'b0;
      stg_data <= '0;
      stg_dp   <= '0;
      stg_en   <= '0;
      shd_data <= '0;
      shd_dp   <= '0;
      shd_en   <= '0;
      an_q     <= AN_OFF;
      seg_q    <= SEG_OFF;
      fd_q     <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) idx <= idx + 2'd1;

      if (bus.load) begin
        stg_data <= bus.data;
        stg_dp   <= bus.dp_in;
        stg_en   <= bus.digit_en;
        pending  <= 1'b1;
      end

      // Frame edge: a coincident load bypasses staging so it is never lost.
      if (boundary) begin
        pending <= 1'b0;
        if (bus.load) begin
          shd_data <= bus.data;
          shd_dp   <= bus.dp_in;
          shd_en   <= bus.digit_en;
        end else if (pending) begin
          shd_data <= stg_data;
          shd_dp   <= stg_dp;
          shd_en   <= stg_en;
        end
      end

      an_q  <= an_d;
      seg_q <= seg_d;
      fd_q  <= boundary;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// Scoreboard bench: expected digit outputs queued per frame, checked per cycle.
module tb_hex_scan_display;

  localparam int DC    = 4;
  localparam int FRAME = 4 * DC;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hex_scan_display_if bus();

  hex_scan_display #(.DIGIT_CYCLES(DC), .CNT_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {logic [3:0] an; logic [7:0] seg;} exp_t;
  typedef struct {int k; logic [15:0] d; logic [3:0] dp; logic [3:0] en;} ld_t;

  localparam logic [6:0] REF [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  exp_t sb[$];
  ld_t  ld_q[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void push_frame(input logic [15:0] d, input logic [3:0] dp,
                                     input logic [3:0] en);
    int msd = 0;
    for (int i = 0; i < 4; i++) if (d[4*i +: 4] != 4'h0) msd = i;
    for (int dg = 0; dg < 4; dg++) begin
      exp_t e;
      logic on;
      on = en[dg];
`ifdef LEADING_ZERO_BLANK_EN
      if (dg > msd) on = 1'b0;
`endif
      e.an  = 4'hF;
      e.seg = 8'hFF;
      if (on) begin
        e.an      = 4'hF;
        e.an[dg]  = 1'b0;
        e.seg     = {~dp[dg], REF[d[4*dg +: 4]]};
      end
      for (int c = 0; c < DC; c++) sb.push_back(e);
    end
  endfunction

  function automatic void push_ld(input int k, input logic [15:0] d,
                                  input logic [3:0] dp, input logic [3:0] en);
    ld_t l;
    l.k = k; l.d = d; l.dp = dp; l.en = en;
    ld_q.push_back(l);
  endfunction

  task automatic sync();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_done && n < 100);
    chk("sync_frame_done", {15'd0, bus.frame_done}, 16'd1);
  endtask

  // Entered on the negedge where frame_done is high; leaves on the next one.
  task automatic check_frame(input string tag);
    for (int k = 0; k < FRAME; k++) begin
      exp_t e;
      @(negedge clk);
      if (sb.size() == 0) begin
        chk({tag, "_sb_empty"}, 16'd0, 16'd1);
      end else begin
        e = sb.pop_front();
        chk({tag, "_an"},  {12'd0, bus.an}, {12'd0, e.an});
        chk({tag, "_seg"}, {8'd0, bus.seg}, {8'd0, e.seg});
      end
      chk({tag, "_fd"}, {15'd0, bus.frame_done}, {15'd0, (k == FRAME - 1)});
      if (ld_q.size() > 0 && ld_q[0].k == k) begin
        bus.data     = ld_q[0].d;
        bus.dp_in    = ld_q[0].dp;
        bus.digit_en = ld_q[0].en;
        bus.load     = 1'b1;
        void'(ld_q.pop_front());
      end else begin
        bus.load = 1'b0;
      end
    end
  endtask

  initial begin
    logic [15:0] rd;
    logic [3:0]  rdp, ren;
    rst          = 1'b1;
    bus.load     = 1'b0;
    bus.data     = 16'h0;
    bus.dp_in    = 4'h0;
    bus.digit_en = 4'h0;

    repeat (2) begin
      @(negedge clk);
      chk("rst_an",  {12'd0, bus.an}, 16'h000F);
      chk("rst_seg", {8'd0, bus.seg}, 16'h00FF);
      chk("rst_fd",  {15'd0, bus.frame_done}, 16'd0);
    end
    rst = 1'b0;

    sync();
    push_frame(16'h0, 4'h0, 4'h0); check_frame("dark0");
    push_frame(16'h0, 4'h0, 4'h0); check_frame("dark1");
    push_frame(16'h0, 4'h0, 4'h0); push_ld(2, 16'h1234, 4'h0, 4'hF);
    check_frame("dark2");

    push_frame(16'h1234, 4'h0, 4'hF);
    push_ld(5, 16'h1111, 4'h0, 4'hF);
    push_ld(9, 16'h2222, 4'h0, 4'hF);
    check_frame("basic");

    push_frame(16'h2222, 4'h0, 4'hF);
    push_ld(FRAME - 2, 16'hABCD, 4'h0, 4'hF);
    check_frame("multi");

    push_frame(16'hABCD, 4'h0, 4'hF);
    push_ld(FRAME - 1, 16'h0000, 4'b0001, 4'b0101);
    check_frame("coinc");

    push_frame(16'hABCD, 4'h0, 4'hF);
    check_frame("post_bnd");

    push_frame(16'h0000, 4'b0001, 4'b0101);
    push_ld(0, 16'h0050, 4'h0, 4'hF);
    check_frame("mask");

    push_frame(16'h0050, 4'h0, 4'hF);
    for (int r = 0; r < 3; r++) begin
      rd  = 16'($urandom);
      rdp = 4'($urandom_range(15));
      ren = 4'($urandom_range(15));
      push_ld(7, rd, rdp, ren);
      check_frame("rand");
      push_frame(rd, rdp, ren);
    end
    check_frame("rand_last");

    // Stage a value, then reset with load held high: neither may appear.
    bus.data = 16'h5678; bus.dp_in = 4'hF; bus.digit_en = 4'hF; bus.load = 1'b1;
    @(negedge clk);
    bus.data = 16'h9999;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_an",  {12'd0, bus.an}, 16'h000F);
    chk("mid_rst_seg", {8'd0, bus.seg}, 16'h00FF);
    chk("mid_rst_fd",  {15'd0, bus.frame_done}, 16'd0);
    bus.load = 1'b0;
    rst = 1'b0;
    sync();
    push_frame(16'h0, 4'h0, 4'h0); check_frame("rst_dark0");
    push_frame(16'h0, 4'h0, 4'h0); check_frame("rst_dark1");
    chk("sb_drained", 16'(sb.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
